// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte sources,
// with busy tracking, inter-byte gap, busy-rise timeout and baud clock-enable.
module uart_tx_scheduler #(
    parameter int NREQ         = 4,
    parameter int IDW          = 2,
    parameter int GAP_BITS     = 1,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic              clk_9600_16,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        tx_din,
    output logic              tx_wr_en,
    input  logic              tx_busy,
    output logic              baud_ce,
    output logic [IDW-1:0]    grant_id,
    output logic              active,
    output logic              err,
    input  logic              err_clr
);

    localparam int TW = (BUSY_TIMEOUT < 1) ? 1 : $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        baud_cnt_q, baud_cnt_d;
    logic              baud_ce_q, baud_ce_d;
    logic [IDW-1:0]    rr_q, rr_d;
    logic [3:0]        gap_q, gap_d;
    logic [TW-1:0]     to_q, to_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [7:0]        tx_din_q, tx_din_d;
    logic              tx_wr_en_q, tx_wr_en_d;
    logic [IDW-1:0]    grant_id_q, grant_id_d;
    logic              active_q, active_d;
    logic              err_q, err_d;

    logic              found;
    logic [IDW-1:0]    sel;
    logic [IDW:0]      idx;
    logic [IDW-1:0]    idx_n;

    always_comb begin
        baud_cnt_d = baud_cnt_q + 4'd1;
        baud_ce_d  = (baud_cnt_q == 4'd15);
    end

    // First pending requester at or above the rr pointer, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        idx_n = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_q} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) begin
                idx = idx - (IDW+1)'(NREQ);
            end
            idx_n = idx[IDW-1:0];
            if (!found && req[idx_n]) begin
                found = 1'b1;
                sel   = idx_n;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        gap_d      = gap_q;
        to_d       = to_q;
        ack_d      = '0;
        tx_wr_en_d = 1'b0;
        tx_din_d   = tx_din_q;
        grant_id_d = grant_id_q;
        active_d   = active_q;
        err_d      = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                active_d = 1'b0;
                if (found) begin
                    tx_din_d   = req_data[32'(sel)*8 +: 8];
                    tx_wr_en_d = 1'b1;
                    ack_d      = NREQ'(1) << sel;
                    grant_id_d = sel;
                    rr_d       = (sel == IDW'(NREQ-1)) ? '0 : sel + IDW'(1);
                    active_d   = 1'b1;
                    to_d       = '0;
                    state_d    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (to_q == TW'(BUSY_TIMEOUT)) begin
                    err_d   = 1'b1;
                    gap_d   = 4'(GAP_BITS);
                    state_d = GAP;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    gap_d   = 4'(GAP_BITS);
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == 4'd0) begin
                    active_d = 1'b0;
                    state_d  = IDLE;
                end else if (baud_ce_q) begin
                    gap_d = gap_q - 4'd1;
                    if (gap_q == 4'd1) begin
                        active_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_9600_16 or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            baud_ce_q  <= 1'b0;
            rr_q       <= '0;
            gap_q      <= '0;
            to_q       <= '0;
            ack_q      <= '0;
            tx_din_q   <= '0;
            tx_wr_en_q <= 1'b0;
            grant_id_q <= '0;
            active_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            baud_ce_q  <= baud_ce_d;
            rr_q       <= rr_d;
            gap_q      <= gap_d;
            to_q       <= to_d;
            ack_q      <= ack_d;
            tx_din_q   <= tx_din_d;
            tx_wr_en_q <= tx_wr_en_d;
            grant_id_q <= grant_id_d;
            active_q   <= active_d;
            err_q      <= err_d;
        end
    end

    assign ack      = ack_q;
    assign tx_din   = tx_din_q;
    assign tx_wr_en = tx_wr_en_q;
    assign baud_ce  = baud_ce_q;
    assign grant_id = grant_id_q;
    assign active   = active_q;
    assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: reset, round robin, gap, baud enable,
// busy timeout with err_clr, and reset in the middle of a byte.
module tb_uart_tx_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk_9600_16 = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] req_data = 32'hD3C2_B1A0;
    logic [NREQ-1:0]   ack;
    logic [7:0]        tx_din;
    logic              tx_wr_en;
    logic              tx_busy;
    logic              baud_ce;
    logic [IDW-1:0]    grant_id;
    logic              active;
    logic              err;
    logic              err_clr = 1'b0;

    logic model_en = 1'b0;
    logic man_busy = 1'b0;
    logic model_busy;
    int   model_cnt;

    int checks = 0;
    int errors = 0;

    uart_tx_scheduler #(
        .NREQ(NREQ),
        .IDW(IDW),
        .GAP_BITS(2),
        .BUSY_TIMEOUT(4)
    ) dut (
        .clk_9600_16(clk_9600_16),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .tx_din(tx_din),
        .tx_wr_en(tx_wr_en),
        .tx_busy(tx_busy),
        .baud_ce(baud_ce),
        .grant_id(grant_id),
        .active(active),
        .err(err),
        .err_clr(err_clr)
    );

    always #5 clk_9600_16 = ~clk_9600_16;

    assign tx_busy = model_en ? model_busy : man_busy;

    // Transmitter stand-in: busy for 160 cycles after each write strobe.
    always @(posedge clk_9600_16 or posedge rst) begin
        if (rst) begin
            model_busy <= 1'b0;
            model_cnt  <= 0;
        end else if (model_en && tx_wr_en) begin
            model_busy <= 1'b1;
            model_cnt  <= 160;
        end else if (model_cnt != 0) begin
            model_cnt <= model_cnt - 1;
            if (model_cnt == 1) model_busy <= 1'b0;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk_9600_16);
        @(negedge clk_9600_16);
        rst = 1'b0;
    endtask

    task automatic wait_wr(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk_9600_16);
            #1;
            if (tx_wr_en) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_wr: no tx_wr_en within 400 cycles, required one");
        end
    endtask

    task automatic test_reset();
        model_en = 1'b1;
        req = 4'b1111;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk_9600_16);
            #1;
            checks++;
            if ({ack, tx_din, tx_wr_en, baud_ce, grant_id, active, err} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: ack=%b din=%h wr=%b ce=%b gid=%0d act=%b err=%b, required all 0",
                         ack, tx_din, tx_wr_en, baud_ce, grant_id, active, err);
            end
        end
        @(negedge clk_9600_16);
        rst = 1'b0;
        @(posedge clk_9600_16);
        #1;
        checks++;
        if (tx_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_wr: got %b required 1", tx_wr_en);
        end
        checks++;
        if (grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_gid: got %0d required 0", grant_id);
        end
        checks++;
        if (ack !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_ack: got %b required 0001", ack);
        end
    endtask

    task automatic test_round_robin();
        logic [IDW-1:0] exp_id [5];
        logic [7:0]     exp_din [5];
        bit ok;
        exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_din = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA0};
        model_en = 1'b1;
        req = 4'b1111;
        do_reset();
        for (int g = 0; g < 5; g++) begin
            wait_wr(ok);
            if (ok) begin
                checks++;
                if (grant_id !== exp_id[g]) begin
                    errors++;
                    $display("FAIL rr_gid[%0d]: got %0d required %0d", g, grant_id, exp_id[g]);
                end
                checks++;
                if (tx_din !== exp_din[g]) begin
                    errors++;
                    $display("FAIL rr_din[%0d]: got %h required %h", g, tx_din, exp_din[g]);
                end
            end
        end
        req = '0;
    endtask

    task automatic test_gap();
        bit ok;
        int n;
        model_en = 1'b0;
        man_busy = 1'b0;
        req = 4'b0100;
        do_reset();
        wait_wr(ok);
        @(posedge clk_9600_16);
        #1;
        man_busy = 1'b1;
        repeat (10) @(posedge clk_9600_16);
        #1;
        man_busy = 1'b0;
        @(posedge clk_9600_16);
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_9600_16);
            #1;
            n++;
            if (tx_wr_en) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || n < 17 || n > 33) begin
            errors++;
            $display("FAIL gap_spacing: got %0d cycles (seen=%b) required 17..33", n, ok);
        end
        checks++;
        if (grant_id !== 2'd2) begin
            errors++;
            $display("FAIL gap_gid: got %0d required 2", grant_id);
        end
        req = '0;
    endtask

    task automatic test_baud();
        int cnt;
        int last;
        model_en = 1'b0;
        req = '0;
        do_reset();
        cnt = 0;
        last = -1;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk_9600_16);
            #1;
            if (baud_ce) begin
                cnt++;
                if (last >= 0) begin
                    checks++;
                    if (i - last != 16) begin
                        errors++;
                        $display("FAIL baud_period: got %0d required 16", i - last);
                    end
                end
                last = i;
            end
        end
        checks++;
        if (cnt != 4) begin
            errors++;
            $display("FAIL baud_count: got %0d required 4", cnt);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        model_en = 1'b0;
        man_busy = 1'b0;
        req = 4'b0010;
        do_reset();
        wait_wr(ok);
        checks++;
        if (grant_id !== 2'd1) begin
            errors++;
            $display("FAIL to_gid: got %0d required 1", grant_id);
        end
        req = '0;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk_9600_16);
            #1;
            if (e == 4) begin
                checks++;
                if (err !== 1'b0) begin
                    errors++;
                    $display("FAIL to_early: err=%b required 0", err);
                end
            end
            if (e == 5) begin
                checks++;
                if (err !== 1'b1) begin
                    errors++;
                    $display("FAIL to_set: err=%b required 1", err);
                end
            end
        end
        err_clr = 1'b1;
        @(posedge clk_9600_16);
        #1;
        err_clr = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL to_clr: err=%b required 0", err);
        end
        req = 4'b1000;
        err_clr = 1'b1;
        wait_wr(ok);
        checks++;
        if (grant_id !== 2'd3) begin
            errors++;
            $display("FAIL to_next_gid: got %0d required 3", grant_id);
        end
        req = '0;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk_9600_16);
            #1;
            if (e == 5) begin
                checks++;
                if (err !== 1'b1) begin
                    errors++;
                    $display("FAIL to_set_wins: err=%b required 1", err);
                end
            end
        end
        err_clr = 1'b0;
    endtask

    task automatic test_mid_reset();
        bit ok;
        model_en = 1'b1;
        req = 4'b0100;
        do_reset();
        wait_wr(ok);
        req = '0;
        repeat (20) @(posedge clk_9600_16);
        #3;
        req = 4'b1111;
        rst = 1'b1;
        #1;
        checks++;
        if (active !== 1'b0 || tx_wr_en !== 1'b0 || ack !== 4'b0000) begin
            errors++;
            $display("FAIL mid_rst_outputs: act=%b wr=%b ack=%b required 0 0 0000",
                     active, tx_wr_en, ack);
        end
        repeat (2) @(posedge clk_9600_16);
        @(negedge clk_9600_16);
        rst = 1'b0;
        wait_wr(ok);
        checks++;
        if (grant_id !== 2'd0 || ack !== 4'b0001) begin
            errors++;
            $display("FAIL mid_rst_regrant: gid=%0d ack=%b required 0 0001", grant_id, ack);
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_gap();
        test_baud();
        test_timeout();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares the single UART transmitter between NREQ byte sources, e.g. the classifier result path, a debug/echo path and a status reporter. It grants one requester at a time, hands its byte to the transmitter with a one-cycle write strobe and tracks the transmitter's busy flag to completion. It then enforces an inter-byte idle gap before the next grant. It also generates the bit-rate clock-enable for the transmitter, which runs in the same clk_9600_16 domain.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of grant index, equal to ceil(log2(NREQ))
GAP_BITS, 1, extra idle bit-times (baud_ce pulses) inserted after each byte (0..15)
BUSY_TIMEOUT, 4, clk cycles allowed for tx_busy to rise after tx_wr_en

Ports:
clk_9600_16  in  1  16x baud clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-high
req  in  NREQ  per-requester send request; held high until matching ack
req_data  in  8*NREQ  byte for requester i at bits [8i+7:8i]; stable while req[i] is high
ack  out  NREQ  one-cycle pulse, byte of requester i accepted
tx_din  out  8  byte to transmitter
tx_wr_en  out  1  one-cycle write strobe to transmitter
tx_busy  in  1  transmitter busy flag
baud_ce  out  1  one-cycle enable every 16 clk cycles; drives transmitter clken
grant_id  out  IDW  index of last granted requester
active  out  1  high from grant until the gap ends
err  out  1  sticky: tx_busy failed to rise within BUSY_TIMEOUT
err_clr  in  1  synchronous clear of err

Behaviour:
- Reset values:
  - Outputs: ack=0, tx_din=0, tx_wr_en=0, baud_ce=0, grant_id=0, active=0, err=0.
  - Internal: baud counter=0, rr pointer=0, state=IDLE, gap and timeout counters=0.
  - rst assertion mid-byte aborts immediately. No ack is re-issued; the requester keeps req high and is served again after reset.
- Baud enable: 4-bit free-running counter. baud_ce is registered and high for exactly one cycle when the counter wraps 15->0, i.e. period 16. It runs in every state.
- All outputs are registered. tx_wr_en, ack and the tx_din load occur on the same edge.
- States:
  - IDLE:
    - If any req bit is high, select the first set index searching upward from the rr pointer, wrapping modulo NREQ.
    - Next edge: tx_din <= req_data[sel], tx_wr_en=1 and ack[sel]=1 for one cycle, grant_id <= sel, rr pointer <= (sel+1) mod NREQ, active=1, then go to WAIT_BUSY.
    - No req: stay; active=0.
  - WAIT_BUSY:
    - On tx_busy=1, go to WAIT_DONE.
    - If tx_busy is still 0 after BUSY_TIMEOUT cycles, set err=1 and go to GAP. The byte is treated as lost.
  - WAIT_DONE: on tx_busy=0, go to GAP with the gap counter=GAP_BITS.
  - GAP:
    - Decrement on each baud_ce.
    - At 0, go to IDLE with active=0.
    - GAP_BITS=0 goes to IDLE on the cycle after busy falls.
- Minimum spacing between tx_wr_en pulses is therefore one byte frame plus GAP_BITS bit-times.
- Fairness: a requester that holds req continuously is granted at least once every NREQ grants.
- Simultaneous requests are resolved only by the rr pointer, never by fixed priority.
- A req bit that drops before its grant is simply skipped, with no ack.
- A requester re-asserting req on the cycle after its ack is queued normally; it wins again only if no other requester is pending.
- err_clr: err <= 0. If err_clr and a new timeout occur in the same cycle, the set wins.
- Out-of-range indices (NREQ not a power of two) are never selected.

Test Plan:
- Reset behaviour:
  - Stimulus: rst high for 3 cycles with req=4'b1111.
  - Response: all outputs 0 during reset.
  - After release: first tx_wr_en one cycle later, grant_id=0, ack=4'b0001.
- Round robin:
  - Stimulus: req=4'b1111 held, requesters re-assert after each ack, behavioural transmitter model busy for 160 cycles.
  - Response: grant_id sequence is 0,1,2,3,0. tx_din matches each requester's byte (0xA0, 0xB1, 0xC2, 0xD3).
- Gap:
  - Stimulus: GAP_BITS=2, single requester 2.
  - Response: the cycle count from tx_busy falling to the next tx_wr_en is between 17 and 33.
- Baud enable: free run for 64 cycles -> exactly 4 baud_ce pulses, each 16 cycles apart.
- Timeout:
  - Stimulus: tx_busy tied 0, req[1]=1.
  - Response: err=1 at BUSY_TIMEOUT+1 cycles after the strobe. The scheduler returns to IDLE and serves the next request.
  - Then pulse err_clr: err returns to 0.
- Reset mid-byte:
  - Stimulus: assert rst during WAIT_DONE.
  - Response: active=0 and tx_wr_en=0 immediately. The pointer returns to 0, so requester 0 is granted first after release.
